// File: rtl/sbox_array_if.sv
// sbox_array_if: valid/ready bus for the multi-lane AES byte-substitution unit.
//   in_valid/in_ready/in_data/in_inv    : input transfer (bytes plus mode bit)
//   out_valid/out_ready/out_data/out_inv : result transfer (bytes plus mode bit)
// master drives the input side and consumes results; slave is the unit.
interface sbox_array_if #(
  parameter int LANES = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [8*LANES-1:0] in_data;
  logic               in_inv;
  logic               out_valid;
  logic               out_ready;
  logic [8*LANES-1:0] out_data;
  logic               out_inv;

  modport master (
    output in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data, out_inv
  );

  modport slave (
    input  in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data, out_inv
  );
endinterface

// File: rtl/sbox_array.sv
// sbox_array: three-stage pipelined AES S-box / inverse S-box over LANES bytes.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : sbox_array_if.slave (input transfer with mode, output transfer with mode)
// S1: input map (inverse affine for inverse mode, then isomorphic map).
// S2: GF((2^4)^2) inversion. S3: inverse isomorphic map, plus affine in forward mode.
// Tower field: GF(4) y^2+y+1, GF(16) x^2+x+phi (phi=2), GF(256) z^2+z+lambda (lambda=0xC).
module sbox_array #(
  parameter int LANES  = 16,
  parameter bit INV_EN = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  sbox_array_if.slave bus
);
  localparam int W = 8 * LANES;

  function automatic logic [1:0] gf4Mul(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
            (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  function automatic logic [3:0] gf16Mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh, hl, ll;
    hh = gf4Mul(a[3:2], b[3:2]);
    hl = gf4Mul(a[3:2], b[1:0]) ^ gf4Mul(a[1:0], b[3:2]);
    ll = gf4Mul(a[1:0], b[1:0]);
    return {hh ^ hl, gf4Mul(hh, 2'b10) ^ ll};
  endfunction

  // In GF(4) the inverse equals the square (0 maps to 0).
  function automatic logic [3:0] gf16Inv(input logic [3:0] a);
    logic [1:0] d, di;
    d  = gf4Mul(gf4Mul(a[3:2], a[3:2]), 2'b10) ^ gf4Mul(a[3:2], a[1:0])
       ^ gf4Mul(a[1:0], a[1:0]);
    di = gf4Mul(d, d);
    return {gf4Mul(a[3:2], di), gf4Mul(a[3:2] ^ a[1:0], di)};
  endfunction

  function automatic logic [7:0] gf256Inv(input logic [7:0] q);
    logic [3:0] d, di;
    d  = gf16Mul(gf16Mul(q[7:4], q[7:4]), 4'hC) ^ gf16Mul(q[7:4], q[3:0])
       ^ gf16Mul(q[3:0], q[3:0]);
    di = gf16Inv(d);
    return {gf16Mul(q[7:4], di), gf16Mul(q[7:4] ^ q[3:0], di)};
  endfunction

  function automatic logic [7:0] isoMap(input logic [7:0] a);
    logic [7:0] q;
    q[7] = a[7] ^ a[5];
    q[6] = a[7] ^ a[6] ^ a[4] ^ a[3] ^ a[2] ^ a[1];
    q[5] = a[7] ^ a[5] ^ a[3] ^ a[2];
    q[4] = a[7] ^ a[5] ^ a[3] ^ a[2] ^ a[1];
    q[3] = a[7] ^ a[6] ^ a[2] ^ a[1];
    q[2] = a[7] ^ a[4] ^ a[3] ^ a[2] ^ a[1];
    q[1] = a[6] ^ a[4] ^ a[1];
    q[0] = a[6] ^ a[1] ^ a[0];
    return q;
  endfunction

  function automatic logic [7:0] isoInv(input logic [7:0] q);
    logic [7:0] a;
    a[7] = q[7] ^ q[6] ^ q[5] ^ q[1];
    a[6] = q[6] ^ q[2];
    a[5] = q[6] ^ q[5] ^ q[1];
    a[4] = q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[1];
    a[3] = q[5] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
    a[2] = q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
    a[1] = q[5] ^ q[4];
    a[0] = q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[0];
    return a;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int unsigned n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] affFwd(input logic [7:0] x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] affInv(input logic [7:0] b);
    return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
  endfunction

  logic         s1Valid, s2Valid, s3Valid;
  logic         s1Inv, s2Inv, s3Inv;
  logic [W-1:0] s1Data, s2Data, s3Data;
  logic [W-1:0] s1Next, s2Next, s3Next;
  logic         s1Load, s2Load, s3Load;
  logic         s1Adv, s2Adv, s3Adv;
  logic         modeIn;

  assign modeIn = INV_EN & bus.in_inv;

  // Advance chain runs backwards from out_ready, so in_ready is combinational on it.
  always_comb begin
    s3Adv  = s3Valid & bus.out_ready;
    s3Load = ~s3Valid | s3Adv;
    s2Adv  = s2Valid & s3Load;
    s2Load = ~s2Valid | s2Adv;
    s1Adv  = s1Valid & s2Load;
    s1Load = ~s1Valid | s1Adv;
  end

  always_comb begin
    s1Next = '0;
    s2Next = '0;
    s3Next = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      s1Next[8*k +: 8] = isoMap(modeIn ? affInv(bus.in_data[8*k +: 8]) : bus.in_data[8*k +: 8]);
      s2Next[8*k +: 8] = gf256Inv(s1Data[8*k +: 8]);
      s3Next[8*k +: 8] = s2Inv ? isoInv(s2Data[8*k +: 8]) : affFwd(isoInv(s2Data[8*k +: 8]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
      s3Valid <= 1'b0;
      s1Inv   <= 1'b0;
      s2Inv   <= 1'b0;
      s3Inv   <= 1'b0;
      s1Data  <= '0;
      s2Data  <= '0;
      s3Data  <= '0;
    end else begin
      if (s1Load) s1Valid <= bus.in_valid;
      if (s1Load && bus.in_valid) begin
        s1Data <= s1Next;
        s1Inv  <= modeIn;
      end
      if (s2Load) s2Valid <= s1Valid;
      if (s1Adv) begin
        s2Data <= s2Next;
        s2Inv  <= s1Inv;
      end
      if (s3Load) s3Valid <= s2Valid;
      if (s2Adv) begin
        s3Data <= s3Next;
        s3Inv  <= s2Inv;
      end
    end
  end

  assign bus.in_ready  = rst_n & s1Load;
  assign bus.out_valid = s3Valid;
  assign bus.out_data  = s3Data;
  assign bus.out_inv   = s3Inv;
endmodule

// File: tb/tb_sbox_array.sv
// tb_sbox_array: scoreboard bench for sbox_array (LANES=16, INV_EN=1).
// Expected results come from the FIPS-197 table and its inverse.
module tb_sbox_array;
  localparam int LANES = 16;
  localparam int W = 8 * LANES;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  typedef struct packed {
    logic [W-1:0] d;
    logic         inv;
  } expT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] invTab [256];
  expT        sbQ [$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  sbox_array_if #(.LANES(LANES)) bus ();

  sbox_array #(.LANES(LANES), .INV_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++)
      r[8*k +: 8] = inv ? invTab[d[8*k +: 8]] : SBOX[d[8*k +: 8]];
    return r;
  endfunction

  function automatic void push(input logic [W-1:0] d, input logic inv);
    expT e;
    e.d = model(d, inv);
    e.inv = inv;
    sbQ.push_back(e);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic inv);
    int waitCyc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_inv   = inv;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        push(d, inv);
        break;
      end
      waitCyc++;
      if (waitCyc > 50) begin
        check("send_timeout", {{(W-1){1'b0}}, bus.in_ready}, 1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every consumed result against the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sbQ.size() == 0) begin
        check("unexpected_out", {{(W-1){1'b0}}, bus.out_valid}, 0);
      end else begin
        expT e;
        e = sbQ.pop_front();
        check("out_data", bus.out_data, e.d);
        check("out_inv", {{(W-1){1'b0}}, bus.out_inv}, {{(W-1){1'b0}}, e.inv});
      end
    end
  end

  initial begin
    logic [W-1:0] d, held;
    logic [W-1:0] fwdRes [16];
    logic [W-1:0] bpData [5];
    int c0, idx;

    for (int i = 0; i < 256; i++) invTab[SBOX[i]] = 8'(i);
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_inv    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    idle(2);
    @(negedge clk);
    check("rst_in_ready", {{(W-1){1'b0}}, bus.in_ready}, 0);
    check("rst_out_valid", {{(W-1){1'b0}}, bus.out_valid}, 0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_out_inv", {{(W-1){1'b0}}, bus.out_inv}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    check("post_rst_in_ready", {{(W-1){1'b0}}, bus.in_ready}, 1);

    // Forward single transfer with latency
    for (int k = 0; k < LANES; k++) d[8*k +: 8] = 8'($urandom_range(255));
    d[31:0] = 32'hFF530100;
    send(d, 1'b0);
    check("lat_s1", {{(W-1){1'b0}}, bus.out_valid}, 0);
    idle(1);
    check("lat_s2", {{(W-1){1'b0}}, bus.out_valid}, 0);
    idle(1);
    check("lat_s3", {{(W-1){1'b0}}, bus.out_valid}, 1);
    check("fwd_lanes", {{(W-32){1'b0}}, bus.out_data[31:0]}, 128'h16ED7C63);
    idle(3);

    // Inverse single transfer
    d[31:0] = 32'h16ED7C63;
    send(d, 1'b1);
    idle(2);
    check("inv_lanes", {{(W-32){1'b0}}, bus.out_data[31:0]}, 128'hFF530100);
    check("inv_mode", {{(W-1){1'b0}}, bus.out_inv}, 1);
    idle(3);

    // Exhaustive forward stream then inverse round trip, back to back
    c0 = cyc;
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < LANES; k++) d[8*k +: 8] = 8'(16 * j + k);
      fwdRes[j] = model(d, 1'b0);
      send(d, 1'b0);
    end
    check("throughput", 128'(cyc - c0), 128'd16);
    for (int j = 0; j < 16; j++) send(fwdRes[j], 1'b1);
    idle(6);

    // Back-pressure: 5 transfers offered while out_ready is low
    for (int j = 0; j < 5; j++)
      for (int k = 0; k < LANES; k++) bpData[j][8*k +: 8] = 8'($urandom_range(255));
    bus.out_ready = 1'b0;
    idx = 0;
    held = '0;
    for (int c = 0; c < 13; c++) begin
      if (c == 8) bus.out_ready = 1'b1;
      if (idx < 5) begin
        bus.in_valid = 1'b1;
        bus.in_data  = bpData[idx];
        bus.in_inv   = 1'b0;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        push(bpData[idx], 1'b0);
        idx++;
      end
      if (c == 3) begin
        held = bus.out_data;
        check("bp_head", held, model(bpData[0], 1'b0));
      end
      if (c > 3 && c < 8) check("bp_hold", bus.out_data, held);
      if (c == 7) begin
        check("bp_accepted", 128'(idx), 128'd3);
        check("bp_in_ready", {{(W-1){1'b0}}, bus.in_ready}, 0);
      end
      if (c >= 8) check("bp_stream", {{(W-1){1'b0}}, bus.out_valid}, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("bp_all_sent", 128'(idx), 128'd5);
    idle(4);

    // Mixed modes back to back
    send({LANES{8'h53}}, 1'b0);
    send({LANES{8'hED}}, 1'b1);
    send({LANES{8'h00}}, 1'b0);
    @(negedge clk);
    check("mix0_data", bus.out_data, {LANES{8'hED}});
    check("mix0_inv", {{(W-1){1'b0}}, bus.out_inv}, 0);
    @(negedge clk);
    check("mix1_data", bus.out_data, {LANES{8'h53}});
    check("mix1_inv", {{(W-1){1'b0}}, bus.out_inv}, 1);
    @(negedge clk);
    check("mix2_data", bus.out_data, {LANES{8'h63}});
    check("mix2_inv", {{(W-1){1'b0}}, bus.out_inv}, 0);
    @(posedge clk); #1;
    idle(3);

    // Reset mid-flight discards everything in the pipe
    send({LANES{8'hAA}}, 1'b0);
    send({LANES{8'h55}}, 1'b1);
    rst_n = 1'b0;
    idle(1);
    check("mrst_out_valid", {{(W-1){1'b0}}, bus.out_valid}, 0);
    check("mrst_out_data", bus.out_data, '0);
    sbQ.delete();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mrst_no_ghost", {{(W-1){1'b0}}, bus.out_valid}, 0);
    end
    @(posedge clk); #1;
    send({LANES{8'h01}}, 1'b0);
    idle(2);
    check("mrst_first", bus.out_data, {LANES{8'h7C}});

    // Drain
    for (int c = 0; c < 100 && sbQ.size() != 0; c++) @(posedge clk);
    #1;
    check("drain", 128'(sbQ.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
